// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store.
// Data wins over fetch within a streak limit; one transaction in flight; optional watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [7:0]        d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;

  localparam int ST_W = (MAX_D_STREAK > 1) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(MAX_D_STREAK);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  logic [2:0]        r_state;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [7:0]        r_memBe;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ifHi;
  logic              r_ifAck;
  logic              r_dAck;
  logic              r_err;
  logic [ST_W-1:0]   r_streak;
  logic [WD_W-1:0]   r_wdog;

  logic w_grantD;
  logic w_grantI;
  logic w_timeout;
  logic w_unused;

  assign w_grantD  = d_req && (!if_req || (r_streak < ST_MAX));
  assign w_grantI  = !w_grantD && if_req;
  // Watchdog fires on the TIMEOUT-th busy cycle; mem_ready in that cycle still wins.
  assign w_timeout = (TIMEOUT > 0) && (r_wdog == WD_LAST);
  assign w_unused  = &{1'b0, if_addr[1:0], d_addr[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memBe    <= '0;
      r_rdata    <= '0;
      r_ifHi     <= 1'b0;
      r_ifAck    <= 1'b0;
      r_dAck     <= 1'b0;
      r_err      <= 1'b0;
      r_streak   <= '0;
      r_wdog     <= '0;
    end else begin
      r_ifAck <= 1'b0;
      r_dAck  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (w_grantD) begin
            r_state    <= S_BUSY_D;
            r_memReq   <= 1'b1;
            r_memWe    <= d_we;
            r_memAddr  <= {d_addr[ADDR_W-1:3], 3'b000};
            r_memWdata <= d_wdata;
            r_memBe    <= d_we ? d_be : 8'hFF;
            if (!if_req)
              r_streak <= '0;
            else if (r_streak != ST_MAX)
              r_streak <= r_streak + 1'b1;
          end else if (w_grantI) begin
            r_state    <= S_BUSY_I;
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b0;
            r_memAddr  <= {if_addr[ADDR_W-1:3], 3'b000};
            r_memWdata <= '0;
            r_memBe    <= 8'hFF;
            r_ifHi     <= if_addr[2];
            r_streak   <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (mem_ready || w_timeout) begin
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
            r_rdata  <= mem_ready ? mem_rdata : '0;
            r_err    <= !mem_ready;
            if (r_state == S_BUSY_D) begin
              r_state <= S_RESP_D;
              r_dAck  <= 1'b1;
            end else begin
              r_state <= S_RESP_I;
              r_ifAck <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RESP_I, S_RESP_D: r_state <= S_IDLE;
        default:            r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ack    = r_ifAck;
  assign if_err    = r_ifAck & r_err;
  assign if_rdata  = r_ifHi ? r_rdata[63:32] : r_rdata[31:0];
  assign d_ack     = r_dAck;
  assign d_err     = r_dAck & r_err;
  assign d_rdata   = r_rdata;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_be    = r_memBe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int MAXS = 4;
   localparam int TMO  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [31:0]   if_rdata;
   logic          if_err;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [7:0]    d_be = '0;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          d_err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [7:0]    mem_be;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: one transaction at a time described by its grant cycle; the ack cycle
   // and the next free cycle follow from when memory answers or the watchdog expires.
   typedef struct {
      bit          isD;
      logic [63:0] addr;
      bit          we;
      logic [63:0] wdata;
      logic [7:0]  be;
   } txn_t;

   txn_t        cur;
   bit          active = 1'b0;
   bit          modelValid = 1'b0;
   int          cyc = 0;
   int          grantCyc = 0;
   int          freeAt = 0;
   int          streak = 0;
   int          resetCyc = -1;
   int          ackCyc = -1;
   bit          ackIsD = 1'b0;
   bit          ackWe = 1'b0;
   bit          ackHi = 1'b0;
   bit          ackErr = 1'b0;
   logic [63:0] ackData = '0;
   bit          ifAckPrev = 1'b0;
   bit          dAckPrev = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%h required=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic checkFlag(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%b required=%b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit ir, input logic [63:0] ia, input bit dr, input bit dw,
                                input logic [63:0] da, input logic [63:0] dwd, input logic [7:0] be);
      if_req  = ir;
      if_addr = ia;
      d_req   = dr;
      d_we    = dw;
      d_addr  = da;
      d_wdata = dwd;
      d_be    = be;
   endtask

   task automatic waitAck(input bit wantD, input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         if (wantD ? d_ack : if_ack) seen = 1'b1;
      end
      checkFlag(tag, seen, 1'b1);
   endtask

   task automatic waitAnyAck(output int who);
      who = 0;
      for (int k = 0; k < 60 && who == 0; k++) begin
         tick();
         if (d_ack) who = 2;
         else if (if_ack) who = 1;
      end
      checkFlag("any_ack_seen", who != 0, 1'b1);
   endtask

   // Reference model, advanced on every sampled edge.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            active     = 1'b0;
            streak     = 0;
            ackCyc     = -1;
            freeAt     = cyc + 1;
            resetCyc   = cyc + 1;
            modelValid = 1'b1;
         end else if (modelValid) begin
            if (active && cyc > grantCyc) begin
               if (mem_ready || (TMO > 0 && cyc - grantCyc == TMO)) begin
                  active  = 1'b0;
                  ackCyc  = cyc + 1;
                  ackIsD  = cur.isD;
                  ackWe   = cur.we;
                  ackHi   = cur.addr[2];
                  ackErr  = !mem_ready;
                  ackData = mem_ready ? mem_rdata : 64'h0;
                  freeAt  = cyc + 2;
               end
            end else if (!active && cyc >= freeAt) begin
               if (d_req && (!if_req || streak < MAXS)) begin
                  cur.isD = 1'b1; cur.addr = d_addr; cur.we = d_we; cur.wdata = d_wdata; cur.be = d_be;
                  active = 1'b1; grantCyc = cyc;
                  streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
               end else if (if_req) begin
                  cur.isD = 1'b0; cur.addr = if_addr; cur.we = 1'b0; cur.wdata = 64'h0; cur.be = 8'hFF;
                  active = 1'b1; grantCyc = cyc;
                  streak = 0;
               end
            end
         end
         cyc++;
      end
   end

   // Compare process: every cycle, mid-period.
   initial begin
      bit expReq;
      logic [31:0] expIf;
      forever begin
         @(negedge clk);
         ifAckPrev = if_ack;
         dAckPrev  = d_ack;
         if (modelValid) begin
            expReq = active && cyc > grantCyc;
            checkFlag("mem_req", mem_req, expReq);
            checkFlag("if_ack", if_ack, (ackCyc == cyc) && !ackIsD);
            checkFlag("d_ack", d_ack, (ackCyc == cyc) && ackIsD);
            if (cyc == resetCyc) begin
               checkOutput("rst_mem_addr", mem_addr, 64'h0);
               checkOutput("rst_mem_wdata", mem_wdata, 64'h0);
               checkOutput("rst_mem_be", 64'(mem_be), 64'h0);
               checkFlag("rst_mem_we", mem_we, 1'b0);
               checkOutput("rst_if_rdata", 64'(if_rdata), 64'h0);
               checkOutput("rst_d_rdata", d_rdata, 64'h0);
               checkFlag("rst_if_err", if_err, 1'b0);
               checkFlag("rst_d_err", d_err, 1'b0);
            end
            if (expReq) begin
               checkOutput("mem_addr", mem_addr, {cur.addr[63:3], 3'b000});
               checkFlag("mem_we", mem_we, cur.we);
               checkOutput("mem_be", 64'(mem_be), 64'((cur.isD && cur.we) ? cur.be : 8'hFF));
               if (cur.we) checkOutput("mem_wdata", mem_wdata, cur.wdata);
            end
            if (ackCyc == cyc) begin
               if (ackIsD) begin
                  checkFlag("d_err", d_err, ackErr);
                  if (!ackWe) checkOutput("d_rdata", d_rdata, ackData);
               end else begin
                  expIf = ackHi ? ackData[63:32] : ackData[31:0];
                  checkFlag("if_err", if_err, ackErr);
                  checkOutput("if_rdata", 64'(if_rdata), 64'(expIf));
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int who;
      int nReq;
      bit seen;
      bit ifPend;
      bit dPend;
      bit stall;
      string order;

      // Reset held 3 cycles with a pending data load.
      reset = 1'b1;
      applyStimulus(0, 64'h0, 1, 0, 64'h100, 64'h0, 8'h00);
      mem_ready = 1'b1;
      mem_rdata = 64'h0123_4567_89AB_CDEF;
      tick(); tick(); tick();
      checkFlag("t1_mem_req_in_reset", mem_req, 1'b0);
      checkFlag("t1_d_ack_in_reset", d_ack, 1'b0);
      checkFlag("t1_if_ack_in_reset", if_ack, 1'b0);
      reset = 1'b0;
      tick();
      checkFlag("t1_mem_req_after", mem_req, 1'b1);
      checkOutput("t1_mem_addr", mem_addr, 64'h100);
      waitAck(1, "t1_d_ack");
      checkOutput("t1_d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      tick();

      // Fetch of the upper word, memory answers at once.
      applyStimulus(1, 64'h1004, 0, 0, 64'h0, 64'h0, 8'h00);
      mem_rdata = 64'hAABBCCDD_11223344;
      tick();
      checkFlag("t2_mem_req", mem_req, 1'b1);
      checkOutput("t2_mem_addr", mem_addr, 64'h1000);
      checkOutput("t2_mem_be", 64'(mem_be), 64'hFF);
      tick();
      checkFlag("t2_if_ack", if_ack, 1'b1);
      checkOutput("t2_if_rdata", 64'(if_rdata), 64'hAABBCCDD);
      checkFlag("t2_if_err", if_err, 1'b0);
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      tick();

      // Simultaneous requests: store goes first, fetch follows.
      applyStimulus(1, 64'h3000, 1, 1, 64'h2003, 64'hDEADBEEF, 8'h0F);
      tick();
      checkOutput("t3_mem_addr", mem_addr, 64'h2000);
      checkFlag("t3_mem_we", mem_we, 1'b1);
      checkOutput("t3_mem_be", 64'(mem_be), 64'h0F);
      checkOutput("t3_mem_wdata", mem_wdata, 64'hDEADBEEF);
      waitAck(1, "t3_d_ack");
      d_req = 1'b0;
      waitAck(0, "t3_if_ack");
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      tick();

      // Both held high: streak limit interleaves one fetch after four data grants.
      applyStimulus(1, 64'h6000, 1, 0, 64'h7000, 64'h0, 8'h00);
      mem_ready = 1'b1;
      order = "";
      for (int t = 0; t < 10; t++) begin
         waitAnyAck(who);
         if (who == 2) order = {order, "D"};
         else if (who == 1) order = {order, "I"};
         else order = {order, "-"};
      end
      checks++;
      if (order != "DDDDIDDDDI") begin
         errors++;
         $display("[TB] FAIL t4_grant_order: got=%s required=DDDDIDDDDI", order);
      end
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      tick();

      // Memory never answers: watchdog aborts after TMO busy cycles.
      applyStimulus(0, 64'h0, 1, 0, 64'h4000, 64'h0, 8'h00);
      mem_ready = 1'b0;
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      nReq = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         if (mem_req) nReq++;
         if (d_ack) seen = 1'b1;
      end
      checkOutput("t5_req_cycles", 64'(nReq), 64'd8);
      checkFlag("t5_d_ack", seen, 1'b1);
      checkFlag("t5_d_err", d_err, 1'b1);
      checkOutput("t5_d_rdata", d_rdata, 64'h0);
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      tick();

      // Reset in the middle of a stalled load; the held request is reissued.
      applyStimulus(0, 64'h0, 1, 0, 64'h5008, 64'h0, 8'h00);
      tick();
      checkFlag("t6_mem_req_busy", mem_req, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      checkFlag("t6_mem_req_reset", mem_req, 1'b0);
      checkFlag("t6_d_ack_reset", d_ack, 1'b0);
      reset = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 64'h5555_AAAA_1234_5678;
      waitAck(1, "t6_d_ack_reissue");
      checkFlag("t6_d_err", d_err, 1'b0);
      checkOutput("t6_d_rdata", d_rdata, 64'h5555_AAAA_1234_5678);
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      tick();

      // Random traffic with occasional resets and a stall-heavy window.
      ifPend = 1'b0;
      dPend  = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         tick();
         stall = (k >= 2000 && k < 2600);
         if (ifPend && ifAckPrev) ifPend = 1'b0;
         if (dPend && dAckPrev) dPend = 1'b0;
         if (!ifPend && $urandom_range(0, 2) == 0) begin
            ifPend  = 1'b1;
            if_addr = {$urandom, $urandom} & ~64'h3;
         end
         if (!dPend && $urandom_range(0, 2) == 0) begin
            dPend   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
            d_be    = 8'($urandom);
         end
         if_req    = ifPend;
         d_req     = dPend;
         reset     = ($urandom_range(0, 399) == 0);
         mem_ready = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
         mem_rdata = {$urandom, $urandom};
      end
      reset = 1'b0;
      applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00);
      mem_ready = 1'b1;
      for (int k = 0; k < 20; k++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
